timer_ctrl: RTL
===============

// Module: timer_ctrl
// PURPOSE
//   Control stage directly upstream of the BCD down-counter chain (min tens, min ones, sec tens, sec ones) in the microwave timer.
//   - Collects keypad digits into a 4-digit BCD entry register.
//   - Drives the chain's parallel-load data and loadn, and gates its count enable from the 1 Hz tick.
//   - Consumes the chain's all-zero flag to end cooking; drives magnetron and done/beep outputs.
// PARAMETERS
//   DONE_TICKS  3  number of tick pulses spent in DONE (beep duration) before returning to IDLE; >=1
// PORTS
//   clk          in   1   single system clock, all state on posedge
//   clr          in   1   asynchronous active-high reset
//   digit        in   4   keypad BCD digit
//   digit_valid  in   1   one-cycle strobe, digit valid
//   start        in   1   one-cycle strobe, start/resume
//   stop         in   1   one-cycle strobe, pause/clear
//   door_closed  in   1   level, 1 = door closed
//   tick         in   1   one-cycle 1 Hz enable pulse
//   timer_zero   in   1   AND of all counter zero flags
//   data         out  16  {min_tens,min_ones,sec_tens,sec_ones} load value to counter chain
//   loadn        out  1   active-low parallel load, registered
//   en           out  1   counter count enable, combinational
//   mag_on       out  1   magnetron drive, registered
//   done         out  1   one-cycle pulse on cook completion
//   beep         out  1   buzzer drive
// BEHAVIOUR
//   - Reset (async, clr=1): state=IDLE, entry=16'h0000, data=0, loadn=1, mag_on=0, done=0, beep=0, DONE tick count=0; en=0 while in reset.
//   - States: IDLE, ENTRY, LOAD, COOK, PAUSE, DONE.
//   - Digit entry (IDLE/ENTRY only): digit_valid & digit<=9 -> entry <= {entry[11:0],digit}, state->ENTRY. Oldest digit falls off.
//     digit>9 ignored. Digits ignored in LOAD/COOK/PAUSE/DONE.
//   - data = entry at all times.
//   - ENTRY + start: proceeds to LOAD only if door_closed, entry!=0, and entry[7:4]<=5. Otherwise ignored, state and entry unchanged.
//   - LOAD: lasts exactly 1 cycle, loadn=0 during it (counters load at that posedge); next state COOK. loadn=1 in every other state.
//   - COOK: mag_on=1; en = tick & door_closed & ~timer_zero (combinational, same cycle as tick). Transitions:
//     - timer_zero=1 -> DONE; done=1 for exactly the first DONE cycle.
//     - stop=1 or door_closed=0 -> PAUSE. mag_on drops the cycle after.
//   - PAUSE: mag_on=0, en=0, counters hold.
//     - start & door_closed -> COOK with no reload.
//     - stop -> entry cleared, IDLE.
//   - stop in ENTRY: entry cleared, IDLE. start/stop in IDLE: ignored.
//   - DONE: counts tick pulses; after DONE_TICKS ticks -> IDLE with entry cleared. stop or digit_valid in DONE -> IDLE immediately.
//   - Simultaneous events:
//     - stop beats start.
//     - start beats digit_valid.
//     - door open beats tick (en=0).
//     - timer_zero beats stop in COOK (-> DONE).
//   - Reset mid-cook: outputs return to reset values asynchronously; mag_on drops immediately.
// CONFIGURATION
//   - TIMER_CTRL_BEEP_EN defined: beep=1 throughout DONE; DONE lasts DONE_TICKS ticks as above.
//   - Not defined: beep tied 0, no DONE tick counter; DONE lasts one cycle (done pulse) then IDLE, entry cleared.
// TESTING
//   - Reset with clr=1 mid-COOK -> mag_on=0, loadn=1, en=0, data=0 immediately; state IDLE after release.
//   - Digits 1,2,3,4 strobed -> data=16'h1234; then 5 -> 16'h2345; digit 4'hA -> no change.
//   - Entry 16'h0070, start -> ignored (sec tens 7). Entry 16'h0105, door closed, start -> loadn=0 one cycle, data=16'h0105, then mag_on=1.
//   - COOK, tick with door_closed=0 -> en=0, PAUSE, mag_on=0 next cycle. Close door, start -> COOK, no loadn pulse.
//   - COOK, timer_zero=1 with tick and stop in same cycle -> en=0, done=1 one cycle, DONE entered.
//     With TIMER_CTRL_BEEP_EN and DONE_TICKS=3: beep=1 for 3 ticks then IDLE, data=0.
//   - PAUSE, start and stop same cycle -> IDLE, entry=0, no COOK.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: keypad entry, load and cook/pause/done sequencing in front of the BCD down-counter chain.
// Latency: loadn/mag_on/done/beep registered (valid the cycle after the deciding event); en combinational from tick.
// Backpressure: none; strobes are consumed in the cycle they appear, ignored when the current state has no use for them.
//
// Ports:
//   clk, clr        system clock; asynchronous active-high reset
//   digit/_valid    keypad BCD digit and its one-cycle strobe
//   start, stop     one-cycle strobes: start/resume, pause/clear
//   door_closed     level, 1 = door closed
//   tick            one-cycle 1 Hz enable
//   timer_zero      counter chain reached 00:00
//   data            {min_tens,min_ones,sec_tens,sec_ones} load value, always equal to the entry register
//   loadn           active-low parallel load, low for the single LOAD cycle
//   en              counter count enable
//   mag_on          magnetron drive
//   done            one-cycle pulse on cook completion
//   beep            buzzer drive
//
// Build option: TIMER_CTRL_BEEP_EN -- when defined, DONE holds beep high for DONE_TICKS tick pulses;
// when undefined, beep is tied low and DONE lasts a single cycle.

module timer_ctrl #(
  parameter int DONE_TICKS = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  digit,
  input  logic        digit_valid,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        tick,
  input  logic        timer_zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic        en,
  output logic        mag_on,
  output logic        done,
  output logic        beep
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] entry, entry_nxt;
  logic        digit_ok;
  logic        start_ok;
  logic        loadn_d, mag_on_d, done_d;

  assign digit_ok = digit_valid && (digit <= 4'd9);
  // A time is accepted only with the door shut, something to count, and a legal seconds-tens digit.
  assign start_ok = door_closed && (entry != 16'h0000) && (entry[7:4] <= 4'd5);
  assign data     = entry;

`ifdef TIMER_CTRL_BEEP_EN
  localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  logic [CW-1:0] tick_cnt, tick_cnt_nxt;
  logic          beep_d;
`endif

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      entry <= 16'h0000;
`ifdef TIMER_CTRL_BEEP_EN
      tick_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      entry <= entry_nxt;
`ifdef TIMER_CTRL_BEEP_EN
      tick_cnt <= tick_cnt_nxt;
`endif
    end
  end

  // Next-state logic; the order of tests inside each state encodes event priority
  // (stop over start, start over digit, timer_zero over stop/door).
  always_comb begin
    state_nxt = state;
    entry_nxt = entry;
`ifdef TIMER_CTRL_BEEP_EN
    tick_cnt_nxt = tick_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (digit_ok) begin
          entry_nxt = {entry[11:0], digit};
          state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (stop) begin
          entry_nxt = 16'h0000;
          state_nxt = S_IDLE;
        end else if (start) begin
          // A rejected start still swallows a coincident digit.
          if (start_ok) state_nxt = S_LOAD;
        end else if (digit_ok) begin
          entry_nxt = {entry[11:0], digit};
        end
      end
      S_LOAD: begin
        state_nxt = S_COOK;
      end
      S_COOK: begin
`ifdef TIMER_CTRL_BEEP_EN
        tick_cnt_nxt = '0;
`endif
        if (timer_zero)                state_nxt = S_DONE;
        else if (stop || !door_closed) state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop) begin
          entry_nxt = 16'h0000;
          state_nxt = S_IDLE;
        end else if (start && door_closed) begin
          state_nxt = S_COOK;
        end
      end
      S_DONE: begin
        if (stop || digit_valid) begin
          entry_nxt = 16'h0000;
          state_nxt = S_IDLE;
        end else begin
`ifdef TIMER_CTRL_BEEP_EN
          if (tick) begin
            if (tick_cnt == CW'(DONE_TICKS - 1)) begin
              entry_nxt = 16'h0000;
              state_nxt = S_IDLE;
            end else begin
              tick_cnt_nxt = tick_cnt + 1'b1;
            end
          end
`else
          entry_nxt = 16'h0000;
          state_nxt = S_IDLE;
`endif
        end
      end
      default: begin
        entry_nxt = 16'h0000;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: registered outputs are decoded from the state being entered,
  // so they line up with the state itself.
  always_comb begin
    en       = (state == S_COOK) && tick && door_closed && !timer_zero;
    loadn_d  = (state_nxt != S_LOAD);
    mag_on_d = (state_nxt == S_COOK);
    done_d   = (state_nxt == S_DONE) && (state != S_DONE);
`ifdef TIMER_CTRL_BEEP_EN
    beep_d   = (state_nxt == S_DONE);
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      loadn  <= 1'b1;
      mag_on <= 1'b0;
      done   <= 1'b0;
    end else begin
      loadn  <= loadn_d;
      mag_on <= mag_on_d;
      done   <= done_d;
    end
  end

`ifdef TIMER_CTRL_BEEP_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) beep <= 1'b0;
    else     beep <= beep_d;
  end
`else
  assign beep = 1'b0;
`endif

endmodule
